// File: rtl/pep_mmacc_splitc_feed_join_n_if.sv
// Chunked feed/join bus: producer (master) drives in_*,
// the joiner (slave) returns the aligned, permuted beat on out_*.
interface pep_mmacc_splitc_feed_join_n_if #(
    parameter int NB_IN      = 4,
    parameter int DATA_W     = 128,
    parameter int PERM_W     = 8,
    parameter int L          = 2,
    parameter int LWE_COEF_W = 10,
    parameter int REQ_CMD_W  = 8
);
    logic [DATA_W-1:0]       in_data;
    logic [DATA_W-1:0]       in_rot_data;
    logic [NB_IN-1:0]        in_data_avail;
    logic [(L+1)*PERM_W-1:0] in_perm_select;
    logic [LWE_COEF_W:0]     in_coef_rot_id0;
    logic [REQ_CMD_W-1:0]    in_rcmd;
    logic [DATA_W-1:0]       out_data;
    logic [DATA_W-1:0]       out_rot_data;
    logic [PERM_W-1:0]       out_perm_select;
    logic [LWE_COEF_W:0]     out_coef_rot_id0;
    logic [REQ_CMD_W-1:0]    out_rcmd;
    logic                    out_data_avail;
    logic                    error;

    modport master (
        output in_data, in_rot_data, in_data_avail,
        output in_perm_select, in_coef_rot_id0, in_rcmd,
        input  out_data, out_rot_data, out_perm_select,
        input  out_coef_rot_id0, out_rcmd,
        input  out_data_avail, error
    );

    modport slave (
        input  in_data, in_rot_data, in_data_avail,
        input  in_perm_select, in_coef_rot_id0, in_rcmd,
        output out_data, out_rot_data, out_perm_select,
        output out_coef_rot_id0, out_rcmd,
        output out_data_avail, error
    );
endinterface

// File: rtl/pep_mmacc_splitc_feed_join_n.sv
// Joins NB_IN skewed chunk streams into one beat, butterfly-permutes rot_data.
// Skew/overflow checking is enabled by PEP_MMACC_SPLITC_JOIN_SKEW_CHECK_EN.
module pep_mmacc_splitc_feed_join_n #(
    parameter int NB_IN      = 4,
    parameter int PSI        = 16,
    parameter int CHUNK_PSI  = PSI / 8,
    parameter int R          = 2,
    parameter int MOD_Q_W    = 8,
    parameter int SKEW_DEPTH = 4,
    parameter int CMD_ID     = NB_IN - 1,
    parameter int SET_ID     = 0,
    parameter int PERM_W     = 8,
    parameter int LWE_COEF_W = 10,
    parameter int REQ_CMD_W  = 8
) (
    input logic clk,
    input logic s_rst,
    pep_mmacc_splitc_feed_join_n_if.slave bus
);
    localparam int L     = $clog2(NB_IN);
    localparam int CW    = CHUNK_PSI * R * MOD_Q_W;
    localparam int DW    = NB_IN * CW;
    localparam int PSW   = (L + 1) * PERM_W;
    localparam int CMD_W = PSW + LWE_COEF_W + 1 + REQ_CMD_W;
    localparam int PW    = $clog2(SKEW_DEPTH);
    localparam int CNT_W = PW + 1;

    logic [NB_IN:0]       push_req;
    logic [NB_IN:0]       push;
    logic [NB_IN:0]       nempty;
    logic [NB_IN:0]       full;
    logic                 pop;
    logic [CW-1:0]        hd [NB_IN];
    logic [CW-1:0]        st [L+1][NB_IN];
    logic [CMD_W-1:0]     hc;
    logic [PSW-1:0]       h_perm;
    logic [LWE_COEF_W:0]  h_rot_id;
    logic [REQ_CMD_W-1:0] h_rcmd;
    logic [DW-1:0]        d_cat;
    logic [DW-1:0]        r_cat;
    logic                 unused_perm;

    assign pop = &nempty;
    assign {h_perm, h_rot_id, h_rcmd} = hc;
    assign unused_perm = ^h_perm;

    // Entry NB_IN is the command FIFO, clocked by chunk CMD_ID.
    for (genvar i = 0; i <= NB_IN; i++) begin : g_fifo
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CNT_W-1:0] cnt;

        if (i < NB_IN) begin : g_req
            assign push_req[i] = bus.in_data_avail[i];
        end else begin : g_req
            assign push_req[i] = bus.in_data_avail[CMD_ID];
        end

        assign nempty[i] = (cnt != '0);
        assign full[i]   = (cnt == CNT_W'(SKEW_DEPTH));
        assign push[i]   = push_req[i] & (~full[i] | pop);

        always_ff @(posedge clk) begin
            if (s_rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CNT_W'(push[i]) - CNT_W'(pop);
            end
        end

        if (i < NB_IN) begin : g_dmem
            logic [CW-1:0] dm [SKEW_DEPTH];
            logic [CW-1:0] rm [SKEW_DEPTH];

            always_ff @(posedge clk) begin
                if (push[i]) begin
                    dm[wr_ptr] <= bus.in_data[i*CW +: CW];
                    rm[wr_ptr] <= bus.in_rot_data[i*CW +: CW];
                end
            end

            assign hd[i]    = dm[rd_ptr];
            assign st[0][i] = rm[rd_ptr];
        end else begin : g_cmem
            logic [CMD_W-1:0] cm [SKEW_DEPTH];

            always_ff @(posedge clk) begin
                if (push[i])
                    cm[wr_ptr] <= {bus.in_perm_select,
                                   bus.in_coef_rot_id0,
                                   bus.in_rcmd};
            end

            assign hc = cm[rd_ptr];
        end
    end

    // Stage s swaps 2^s-wide blocks; the pair bit comes from level s+1.
    for (genvar s = 0; s < L; s++) begin : g_stage
        for (genvar j = 0; j < NB_IN; j++) begin : g_chunk
            localparam int SEL = (s + 1) * PERM_W
                               + SET_ID * (NB_IN >> (s + 1))
                               + (j >> (s + 1));
            assign st[s+1][j] = h_perm[SEL] ? st[s][j ^ (1 << s)]
                                            : st[s][j];
        end
    end

    for (genvar j = 0; j < NB_IN; j++) begin : g_cat
        assign d_cat[j*CW +: CW] = hd[j];
        assign r_cat[j*CW +: CW] = st[L][j];
    end

    always_ff @(posedge clk) begin
        if (s_rst) bus.out_data_avail <= 1'b0;
        else       bus.out_data_avail <= pop;
    end

    // Payload has no reset: out_data_avail alone qualifies it.
    always_ff @(posedge clk) begin
        if (pop) begin
            bus.out_data         <= d_cat;
            bus.out_rot_data     <= r_cat;
            bus.out_perm_select  <= h_perm[PERM_W-1:0];
            bus.out_coef_rot_id0 <= h_rot_id;
            bus.out_rcmd         <= h_rcmd;
        end
    end

`ifdef PEP_MMACC_SPLITC_JOIN_SKEW_CHECK_EN
    localparam int AGE_W = CNT_W + 1;

    logic [AGE_W-1:0] age;
    logic             err_q;
    logic             ovf;

    assign ovf = (|(push_req & full)) & ~pop;

    // Age of the oldest waiting partial beat; saturates past the limit.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            age   <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop || nempty == '0)
                age <= '0;
            else if (age <= AGE_W'(SKEW_DEPTH))
                age <= age + 1'b1;
            if (ovf || age > AGE_W'(SKEW_DEPTH))
                err_q <= 1'b1;
        end
    end

    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_pep_mmacc_splitc_feed_join_n.sv
// Scoreboard bench: queue-based join model with a per-pair swap
// permutation model, checked by an independent output monitor.
module tb_pep_mmacc_splitc_feed_join_n;
    localparam int NB_IN      = 4;
    localparam int CHUNK_PSI  = 2;
    localparam int R          = 2;
    localparam int MOD_Q_W    = 8;
    localparam int SKEW_DEPTH = 4;
    localparam int CMD_ID     = NB_IN - 1;
    localparam int SET_ID     = 0;
    localparam int PERM_W     = 8;
    localparam int LWE_COEF_W = 10;
    localparam int REQ_CMD_W  = 8;
    localparam int L          = 2;
    localparam int CW         = CHUNK_PSI * R * MOD_Q_W;
    localparam int DW         = NB_IN * CW;
    localparam int PSW        = (L + 1) * PERM_W;

`ifdef PEP_MMACC_SPLITC_JOIN_SKEW_CHECK_EN
    localparam logic SKEW_EN = 1'b1;
`else
    localparam logic SKEW_EN = 1'b0;
`endif

    typedef struct packed {
        logic [PSW-1:0]       p;
        logic [LWE_COEF_W:0]  id;
        logic [REQ_CMD_W-1:0] c;
    } cmd_t;

    typedef struct {
        int unsigned          cyc;
        logic [DW-1:0]        d;
        logic [DW-1:0]        r;
        logic [PERM_W-1:0]    p;
        logic [LWE_COEF_W:0]  id;
        logic [REQ_CMD_W-1:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        s_rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t        sb [$];
    logic [CW-1:0] qd [NB_IN][$];
    logic [CW-1:0] qr [NB_IN][$];
    cmd_t        qc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pep_mmacc_splitc_feed_join_n_if #(
        .NB_IN(NB_IN), .DATA_W(DW), .PERM_W(PERM_W), .L(L),
        .LWE_COEF_W(LWE_COEF_W), .REQ_CMD_W(REQ_CMD_W)
    ) bus ();

    pep_mmacc_splitc_feed_join_n #(
        .NB_IN(NB_IN), .PSI(16), .CHUNK_PSI(CHUNK_PSI), .R(R),
        .MOD_Q_W(MOD_Q_W), .SKEW_DEPTH(SKEW_DEPTH), .CMD_ID(CMD_ID),
        .SET_ID(SET_ID), .PERM_W(PERM_W), .LWE_COEF_W(LWE_COEF_W),
        .REQ_CMD_W(REQ_CMD_W)
    ) u_dut (
        .clk(clk),
        .s_rst(s_rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; the model retires a beat when every
    // queue already holds an entry, then accepts pushes with room.
    task automatic step(input logic [NB_IN-1:0] av,
                        input logic [PSW-1:0] ps);
        logic [DW-1:0] din;
        logic [DW-1:0] rin;
        logic [CW-1:0] rc [NB_IN];
        int            ord [NB_IN];
        cmd_t          cmd;
        cmd_t          hc;
        exp_t          e;
        bit            all;
        int            d;
        int            t;
        for (int i = 0; i < NB_IN; i++) begin
            din[i*CW +: CW] = $urandom;
            rin[i*CW +: CW] = $urandom;
        end
        cmd.p  = ps;
        cmd.id = (LWE_COEF_W+1)'($urandom);
        cmd.c  = REQ_CMD_W'($urandom);
        bus.in_data         = din;
        bus.in_rot_data     = rin;
        bus.in_data_avail   = av;
        bus.in_perm_select  = cmd.p;
        bus.in_coef_rot_id0 = cmd.id;
        bus.in_rcmd         = cmd.c;
        all = (qc.size() > 0);
        for (int i = 0; i < NB_IN; i++)
            if (qd[i].size() == 0) all = 1'b0;
        if (all) begin
            hc  = qc.pop_front();
            e.d = '0;
            e.r = '0;
            for (int i = 0; i < NB_IN; i++) begin
                e.d[i*CW +: CW] = qd[i].pop_front();
                rc[i]  = qr[i].pop_front();
                ord[i] = i;
            end
            for (int s = 0; s < L; s++) begin
                d = 1 << s;
                for (int k = 0; k < NB_IN / (2 * d); k++) begin
                    if (hc.p[(s+1)*PERM_W + SET_ID*(NB_IN/(2*d)) + k]) begin
                        for (int m = 0; m < d; m++) begin
                            t = ord[k*2*d + m];
                            ord[k*2*d + m] = ord[k*2*d + d + m];
                            ord[k*2*d + d + m] = t;
                        end
                    end
                end
            end
            for (int j = 0; j < NB_IN; j++)
                e.r[j*CW +: CW] = rc[ord[j]];
            e.p   = hc.p[PERM_W-1:0];
            e.id  = hc.id;
            e.c   = hc.c;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        for (int i = 0; i < NB_IN; i++) begin
            if (av[i] && qd[i].size() < SKEW_DEPTH) begin
                qd[i].push_back(din[i*CW +: CW]);
                qr[i].push_back(rin[i*CW +: CW]);
            end
        end
        if (av[CMD_ID] && qc.size() < SKEW_DEPTH) qc.push_back(cmd);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step('0, '0);
    endtask

    task automatic do_reset(input int n);
        s_rst = 1'b1;
        bus.in_data_avail = '0;
        for (int i = 0; i < NB_IN; i++) begin
            qd[i].delete();
            qr[i].delete();
        end
        qc.delete();
        sb.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        chk("rst_avail", DW'(bus.out_data_avail), '0);
        chk("rst_error", DW'(bus.error), '0);
        s_rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!s_rst && bus.out_data_avail === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid got 1 want 0 at cycle %0d",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("latency", DW'(cyc), DW'(e.cyc));
                chk("out_data", bus.out_data, e.d);
                chk("out_rot_data", bus.out_rot_data, e.r);
                chk("out_perm", DW'(bus.out_perm_select), DW'(e.p));
                chk("out_rot_id0", DW'(bus.out_coef_rot_id0), DW'(e.id));
                chk("out_rcmd", DW'(bus.out_rcmd), DW'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PSW-1:0] ps_a;
        logic [PSW-1:0] ps_b;
        ps_a = (PSW'(1) << PERM_W) | (PSW'(1) << (2 * PERM_W));
        ps_b = PSW'(3) << PERM_W;
        bus.in_data         = '0;
        bus.in_rot_data     = '0;
        bus.in_data_avail   = '0;
        bus.in_perm_select  = '0;
        bus.in_coef_rot_id0 = '0;
        bus.in_rcmd         = '0;
        do_reset(3);

        step(4'b1111, '0);
        drain(4);
        step(4'b1111, ps_a);
        step(4'b1111, ps_b);
        step(4'b1111, ps_a | ps_b);
        drain(4);

        step(4'b0001, PSW'($urandom));
        step(4'b0000, '0);
        step(4'b0000, '0);
        step(4'b1110, PSW'($urandom));
        drain(4);
        chk("err_skew3", DW'(bus.error), '0);

        repeat (300) step(NB_IN'($urandom), PSW'($urandom));
        drain(6);
        chk("sb_drained_rand", DW'(sb.size()), '0);

        do_reset(2);
        repeat (5) step(4'b0001, PSW'($urandom));
        chk("err_overflow", DW'(bus.error), DW'(SKEW_EN));
        repeat (4) step(4'b1110, PSW'($urandom));
        drain(4);
        chk("err_sticky", DW'(bus.error), DW'(SKEW_EN));
        chk("sb_drained_ovf", DW'(sb.size()), '0);

        do_reset(2);
        step(4'b0111, PSW'($urandom));
        step(4'b0111, PSW'($urandom));
        do_reset(2);
        drain(3);
        step(4'b1111, PSW'($urandom));
        drain(4);
        chk("sb_drained_end", DW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
